// File: rtl/poly_voice_synth.sv
// rtl/poly_voice_synth.sv - time-multiplexed polyphonic sine synth with per-voice envelope and mixer
module poly_voice_synth #(
    parameter int NUM_VOICES   = 12,
    parameter int PHASE_W      = 32,
    parameter int ENV_W        = 8,
    parameter int ATTACK_STEP  = 16,
    parameter int RELEASE_STEP = 8,
    parameter int MIX_SHIFT    = 2
) (
    input  logic                          Clock,
    input  logic                          nStart,
    input  logic                          SampleTick,
    input  logic [NUM_VOICES-1:0]         Select,
    input  logic [2:0]                    Octave,
    input  logic [NUM_VOICES*PHASE_W-1:0] BaseInc,
    output logic signed [15:0]            Out,
    output logic                          OutValid,
    output logic                          Busy,
    output logic                          Overrun
);

    localparam int VW = $clog2(NUM_VOICES);
    localparam int AW = 16 + $clog2(NUM_VOICES) + 1;
    localparam logic [ENV_W-1:0] ENV_MAX = '1;
    localparam logic [ENV_W:0] ATK = (ENV_W+1)'(ATTACK_STEP);
    localparam logic [ENV_W-1:0] REL = ENV_W'(RELEASE_STEP);
    localparam logic signed [AW-1:0] SAT_HI = AW'(32767);
    localparam logic signed [AW-1:0] SAT_LO = AW'(-32768);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUTPUT} state_t;

    state_t                   state;
    logic [PHASE_W-1:0]       phase [NUM_VOICES];
    logic [ENV_W-1:0]         env   [NUM_VOICES];
    logic [NUM_VOICES-1:0]    sel_snap;
    logic [2:0]               oct_snap;
    logic [VW-1:0]            vidx;
    logic                     drain_cnt;
    logic signed [15:0]       rom_q;
    logic [ENV_W-1:0]         env_q;
    logic                     rom_valid;
    logic signed [15:0]       prod;
    logic                     prod_valid;
    logic signed [AW-1:0]     acc;

    // First quadrant of the sine table, 0..64 inclusive; the rest is mirrored.
    function automatic logic [15:0] qsine(input logic [6:0] i);
        case (i)
            7'd0:  qsine = 16'd0;     7'd1:  qsine = 16'd804;   7'd2:  qsine = 16'd1608;  7'd3:  qsine = 16'd2411;
            7'd4:  qsine = 16'd3212;  7'd5:  qsine = 16'd4011;  7'd6:  qsine = 16'd4808;  7'd7:  qsine = 16'd5602;
            7'd8:  qsine = 16'd6393;  7'd9:  qsine = 16'd7179;  7'd10: qsine = 16'd7962;  7'd11: qsine = 16'd8739;
            7'd12: qsine = 16'd9512;  7'd13: qsine = 16'd10278; 7'd14: qsine = 16'd11039; 7'd15: qsine = 16'd11793;
            7'd16: qsine = 16'd12539; 7'd17: qsine = 16'd13279; 7'd18: qsine = 16'd14010; 7'd19: qsine = 16'd14732;
            7'd20: qsine = 16'd15446; 7'd21: qsine = 16'd16151; 7'd22: qsine = 16'd16846; 7'd23: qsine = 16'd17530;
            7'd24: qsine = 16'd18204; 7'd25: qsine = 16'd18868; 7'd26: qsine = 16'd19519; 7'd27: qsine = 16'd20159;
            7'd28: qsine = 16'd20787; 7'd29: qsine = 16'd21403; 7'd30: qsine = 16'd22005; 7'd31: qsine = 16'd22594;
            7'd32: qsine = 16'd23170; 7'd33: qsine = 16'd23731; 7'd34: qsine = 16'd24279; 7'd35: qsine = 16'd24811;
            7'd36: qsine = 16'd25329; 7'd37: qsine = 16'd25832; 7'd38: qsine = 16'd26319; 7'd39: qsine = 16'd26790;
            7'd40: qsine = 16'd27245; 7'd41: qsine = 16'd27683; 7'd42: qsine = 16'd28105; 7'd43: qsine = 16'd28510;
            7'd44: qsine = 16'd28898; 7'd45: qsine = 16'd29268; 7'd46: qsine = 16'd29621; 7'd47: qsine = 16'd29956;
            7'd48: qsine = 16'd30273; 7'd49: qsine = 16'd30571; 7'd50: qsine = 16'd30852; 7'd51: qsine = 16'd31113;
            7'd52: qsine = 16'd31356; 7'd53: qsine = 16'd31580; 7'd54: qsine = 16'd31785; 7'd55: qsine = 16'd31971;
            7'd56: qsine = 16'd32137; 7'd57: qsine = 16'd32285; 7'd58: qsine = 16'd32412; 7'd59: qsine = 16'd32521;
            7'd60: qsine = 16'd32609; 7'd61: qsine = 16'd32678; 7'd62: qsine = 16'd32728; 7'd63: qsine = 16'd32757;
            default: qsine = 16'd32767;
        endcase
    endfunction

    logic [7:0]               rom_addr;
    logic [6:0]               q_lo;
    logic [6:0]               q_idx;
    logic [15:0]              q_mag;
    logic signed [15:0]       rom_val;
    logic [PHASE_W-1:0]       inc_base;
    logic [PHASE_W-1:0]       inc;
    logic [ENV_W-1:0]         env_cur;
    logic [ENV_W:0]           env_up;
    logic [ENV_W-1:0]         env_next;
    logic signed [16+ENV_W:0] mult;
    logic signed [15:0]       prod_next;
    logic signed [AW-1:0]     acc_next;
    logic signed [AW-1:0]     mixed;
    logic signed [15:0]       out_sat;

    always_comb begin
        rom_addr = phase[vidx][PHASE_W-1 -: 8];
        q_lo     = rom_addr[6:0];
        q_idx    = (q_lo > 7'd64) ? 7'(8'd128 - {1'b0, q_lo}) : q_lo;
        q_mag    = qsine(q_idx);
        rom_val  = rom_addr[7] ? -$signed(q_mag) : $signed(q_mag);

        inc_base = BaseInc[int'(vidx)*PHASE_W +: PHASE_W];
        inc      = inc_base << oct_snap;

        env_cur  = env[vidx];
        env_up   = {1'b0, env_cur} + ATK;
        if (sel_snap[vidx])
            env_next = (env_up > {1'b0, ENV_MAX}) ? ENV_MAX : env_up[ENV_W-1:0];
        else
            env_next = (env_cur < REL) ? '0 : env_cur - REL;

        // Taking bits above ENV_W of the signed product is an arithmetic shift (floor).
        mult      = rom_q * $signed({1'b0, env_q});
        prod_next = mult[ENV_W +: 16];

        acc_next = prod_valid ? acc + $signed({{(AW-16){prod[15]}}, prod}) : acc;
        mixed    = acc_next >>> MIX_SHIFT;
        if (mixed > SAT_HI)
            out_sat = 16'sh7FFF;
        else if (mixed < SAT_LO)
            out_sat = 16'sh8000;
        else
            out_sat = mixed[15:0];
    end

    always_ff @(posedge Clock or negedge nStart) begin
        if (!nStart) begin
            state      <= IDLE;
            for (int i = 0; i < NUM_VOICES; i++) begin
                phase[i] <= '0;
                env[i]   <= '0;
            end
            sel_snap   <= '0;
            oct_snap   <= '0;
            vidx       <= '0;
            drain_cnt  <= 1'b0;
            rom_q      <= '0;
            env_q      <= '0;
            rom_valid  <= 1'b0;
            prod       <= '0;
            prod_valid <= 1'b0;
            acc        <= '0;
            Out        <= '0;
            OutValid   <= 1'b0;
            Busy       <= 1'b0;
            Overrun    <= 1'b0;
        end else begin
            OutValid   <= 1'b0;
            rom_valid  <= 1'b0;
            prod       <= prod_next;
            prod_valid <= rom_valid;
            acc        <= acc_next;
            if (SampleTick && state != IDLE)
                Overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (SampleTick) begin
                        sel_snap <= Select;
                        oct_snap <= Octave;
                        acc      <= '0;
                        vidx     <= '0;
                        Busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    rom_q       <= rom_val;
                    env_q       <= env_cur;
                    rom_valid   <= 1'b1;
                    phase[vidx] <= phase[vidx] + inc;
                    env[vidx]   <= env_next;
                    if (vidx == VW'(NUM_VOICES-1)) begin
                        drain_cnt <= 1'b0;
                        state     <= DRAIN;
                    end else begin
                        vidx <= vidx + 1'b1;
                    end
                end
                DRAIN: begin
                    // Second drain cycle: the last product is being accumulated right now.
                    if (drain_cnt) begin
                        Out      <= out_sat;
                        OutValid <= 1'b1;
                        Busy     <= 1'b0;
                        state    <= OUTPUT;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                OUTPUT: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_poly_voice_synth.sv
// tb/tb_poly_voice_synth.sv - directed self-checking bench for poly_voice_synth
module tb_poly_voice_synth;

    localparam int N  = 12;
    localparam int NS = 4;
    localparam logic [31:0] P28 = 32'h1000_0000;
    localparam logic [31:0] P30 = 32'h4000_0000;
    localparam logic [31:0] P31 = 32'h8000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 nStart = 1'b0;
    logic                 tick = 1'b0;
    logic [N-1:0]         sel = '0;
    logic [2:0]           oct = '0;
    logic [N*32-1:0]      base = '0;
    logic signed [15:0]   out_m;
    logic                 valid_m, busy_m, ovr_m;
    logic [NS-1:0]        sel_s = '0;
    logic [NS*32-1:0]     base_s = '0;
    logic signed [15:0]   out_s;
    logic                 valid_s, busy_s, ovr_s;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0]        vv, vvs;
    logic signed [15:0] got;
    int                 pulses;

    poly_voice_synth #(.NUM_VOICES(N), .ATTACK_STEP(64), .RELEASE_STEP(32), .MIX_SHIFT(4)) u_main (
        .Clock(clk), .nStart(nStart), .SampleTick(tick), .Select(sel), .Octave(oct),
        .BaseInc(base), .Out(out_m), .OutValid(valid_m), .Busy(busy_m), .Overrun(ovr_m));

    poly_voice_synth #(.NUM_VOICES(NS), .ATTACK_STEP(64), .RELEASE_STEP(32), .MIX_SHIFT(0)) u_sat (
        .Clock(clk), .nStart(nStart), .SampleTick(tick), .Select(sel_s), .Octave(oct),
        .BaseInc(base_s), .Out(out_s), .OutValid(valid_s), .Busy(busy_s), .Overrun(ovr_s));

    task automatic chk(input string tag, input logic signed [63:0] seen, input logic signed [63:0] want);
        n_cmp++;
        if (seen !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, seen, want);
        end
    endtask

    function automatic logic [N*32-1:0] all_base(input logic [31:0] b);
        logic [N*32-1:0] r;
        for (int i = 0; i < N; i++) r[i*32 +: 32] = b;
        return r;
    endfunction

    function automatic logic [NS*32-1:0] all_base_s(input logic [31:0] b);
        logic [NS*32-1:0] r;
        for (int i = 0; i < NS; i++) r[i*32 +: 32] = b;
        return r;
    endfunction

    // One sample: tick, scramble Select/Octave mid-run, record valid/busy per cycle for 20 cycles.
    task automatic run_tick(input string tag, input logic [N-1:0] s, input logic [2:0] o,
                            input logic [N*32-1:0] b, input logic signed [15:0] exp_m, input logic chk_m,
                            input logic signed [15:0] exp_s, input logic chk_s);
        logic [31:0] busy_v, val_v, val_vs;
        logic signed [15:0] got_m, got_s;
        busy_v = '0; val_v = '0; val_vs = '0; got_m = 'x; got_s = 'x;
        @(negedge clk); sel = s; oct = o; base = b; tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        for (int j = 1; j <= N + 8; j++) begin
            if (j > 1) @(negedge clk);
            if (j == 3) begin sel = ~s; oct = o + 3'd1; end
            busy_v[j] = busy_m;
            val_v[j]  = valid_m;
            val_vs[j] = valid_s;
            if (valid_m) got_m = out_m;
            if (valid_s) got_s = out_s;
        end
        if (chk_m) begin
            chk({tag, "_busy"}, busy_v, 32'h0000_7FFE);
            chk({tag, "_valid"}, val_v, 32'h0000_8000);
            chk({tag, "_out"}, got_m, exp_m);
        end
        if (chk_s) begin
            chk({tag, "_svalid"}, val_vs, 32'h0000_0080);
            chk({tag, "_sout"}, got_s, exp_s);
        end
    endtask

    task automatic v0(input string tag, input logic s0, input logic [2:0] o, input logic [31:0] b0,
                      input logic signed [15:0] e);
        logic [N*32-1:0] b;
        b = '0;
        b[31:0] = b0;
        run_tick(tag, {{(N-1){1'b0}}, s0}, o, b, e, 1'b1, 16'sd0, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N*32-1:0] b;
        @(negedge clk);
        chk("rst_out", out_m, 0);
        chk("rst_valid", valid_m, 0);
        chk("rst_busy", busy_m, 0);
        chk("rst_ovr", ovr_m, 0);
        repeat (2) @(negedge clk);
        nStart = 1'b1;
        repeat (2) @(negedge clk);

        // Voice 0 parked at address 64, then attack / release with ATTACK 64, RELEASE 32.
        v0("m01", 0, 0, P30, 0);
        v0("m02", 1, 0, 0, 0);
        v0("m03", 1, 0, 0, 511);
        v0("m04", 1, 0, 0, 1023);
        v0("m05", 1, 0, 0, 1535);
        v0("m06", 1, 0, 0, 2039);
        v0("m07", 0, 0, 0, 2039);
        v0("m08", 0, 0, 0, 1783);
        v0("m09", 0, 0, 0, 1527);
        v0("m10", 0, 0, 0, 1271);
        v0("m11", 0, 0, 0, 1015);
        v0("m12", 0, 0, 0, 759);
        v0("m13", 0, 0, 0, 503);
        v0("m14", 0, 0, 0, 247);
        v0("m15", 0, 0, 0, 0);
        v0("m16", 1, 0, 0, 0);
        v0("m17", 1, 0, 0, 511);
        v0("m18", 1, 0, 0, 1023);
        v0("m19", 1, 0, 0, 1535);
        // Octave transposition: 2^28 << 2 steps a quarter wave; << 7 overflows to zero; << 3 half wave.
        v0("m20", 1, 2, P28, 2039);
        v0("m21", 1, 2, P28, 0);
        v0("m22", 1, 2, P28, -2040);
        v0("m23", 1, 2, P28, 0);
        v0("m24", 1, 7, P28, 2039);
        v0("m25", 1, 7, P28, 2039);
        v0("m26", 1, 3, P28, 2039);
        v0("m27", 1, 3, P28, -2040);

        // All voices aligned at address 64 and ramped to full envelope.
        b = all_base(P30);
        b[31:0] = '0;
        run_tick("a28", '1, 0, b, 2039, 1'b1, 0, 1'b1);
        run_tick("a29", '1, 0, '0, 7671, 1'b1, 0, 1'b1);
        run_tick("a30", '1, 0, '0, 13303, 1'b1, 0, 1'b1);
        run_tick("a31", '1, 0, '0, 18935, 1'b1, 0, 1'b1);
        run_tick("a32", '1, 0, '0, 24479, 1'b1, 0, 1'b1);

        chk("ovr_pre", ovr_m, 0);
        vv = '0; vvs = '0; got = 'x;
        @(negedge clk); sel = '1; oct = '0; base = '0; tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        for (int j = 1; j <= N + 8; j++) begin
            if (j > 1) @(negedge clk);
            if (j == 5) tick = 1'b1;
            if (j == 6) tick = 1'b0;
            vv[j]  = valid_m;
            vvs[j] = valid_s;
            if (valid_m) got = out_m;
        end
        chk("ovr_valid", vv, 32'h0000_8000);
        chk("ovr_svalid", vvs, 32'h0000_0080);
        chk("ovr_out", got, 24479);
        chk("ovr_flag", ovr_m, 1);
        chk("ovr_sflag", ovr_s, 1);
        run_tick("a33", '1, 0, '0, 24479, 1'b1, 0, 1'b1);
        chk("ovr_sticky", ovr_m, 1);

        // Four-voice instance with no mix shift: saturation at both rails.
        sel_s = '1; base_s = all_base_s(P30);
        run_tick("s1", '0, 0, '0, 0, 1'b0, 0, 1'b1);
        base_s = '0;
        run_tick("s2", '0, 0, '0, 0, 1'b0, 32764, 1'b1);
        run_tick("s3", '0, 0, '0, 0, 1'b0, 32767, 1'b1);
        run_tick("s4", '0, 0, '0, 0, 1'b0, 32767, 1'b1);
        base_s = all_base_s(P31);
        run_tick("s5", '0, 0, '0, 0, 1'b0, 32767, 1'b1);
        base_s = '0;
        run_tick("s6", '0, 0, '0, 0, 1'b0, -32768, 1'b1);

        // Asynchronous reset in the middle of a run.
        @(negedge clk); sel = '1; tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        repeat (4) @(negedge clk);
        #2 nStart = 1'b0;
        #1;
        chk("mid_rst_out", out_m, 0);
        chk("mid_rst_valid", valid_m, 0);
        chk("mid_rst_busy", busy_m, 0);
        chk("mid_rst_ovr", ovr_m, 0);
        chk("mid_rst_sout", out_s, 0);
        chk("mid_rst_sovr", ovr_s, 0);
        repeat (2) @(negedge clk);
        nStart = 1'b1;
        pulses = 0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            pulses += int'(valid_m) + int'(valid_s);
        end
        chk("idle_no_valid", pulses, 0);
        sel_s = '0;
        run_tick("post_rst", '1, 0, '0, 0, 1'b1, 0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/poly_voice_synth.md
Name: poly_voice_synth

Overview:
Parametrised polyphonic tone generator. It produces NUM_VOICES oscillator channels from one shared 256x16 sine ROM, using time-multiplexed voices instead of one ROM per note. It adds a per-voice attack/release envelope, octave transposition and a sample-rate strobe. It sits between the step-sequencer note selector and the audio codec interface, producing one mixed signed 16-bit sample per SampleTick.

Parameters:
NUM_VOICES, 12, number of oscillator channels (2..32)
PHASE_W, 32, phase accumulator width; ROM address = phase[PHASE_W-1 -: 8]
ENV_W, 8, envelope width; envelope max = 2^ENV_W-1
ATTACK_STEP, 16, envelope increment per sample while voice selected
RELEASE_STEP, 8, envelope decrement per sample while voice deselected
MIX_SHIFT, 2, arithmetic right shift applied to the voice sum before saturation

Ports:
Clock  in  1  system clock
nStart  in  1  asynchronous active-low reset
SampleTick  in  1  one-cycle sample-rate strobe
Select  in  NUM_VOICES  note gate per voice
Octave  in  3  transposition; effective increment = BaseInc[v] << Octave
BaseInc  in  NUM_VOICES*PHASE_W  packed per-voice base phase increments, voice v at [v*PHASE_W +: PHASE_W]
Out  out  16  signed mixed sample
OutValid  out  1  one-cycle pulse when Out updates
Busy  out  1  high while a sample is being computed
Overrun  out  1  sticky: SampleTick arrived while Busy

Behaviour:
- Reset (nStart low, asynchronous) takes effect immediately, including mid-computation:
  - all phase[v]=0, env[v]=0, accumulator=0, state IDLE;
  - Out=0, OutValid=0, Busy=0, Overrun=0.
- States: IDLE -> RUN -> DRAIN -> OUTPUT -> IDLE.
- IDLE: SampleTick high in cycle k:
  - snapshot Select and Octave, clear accumulator, voice index v=0;
  - go to RUN; Busy=1 from k+1.
- RUN: one voice per cycle, v=0..NUM_VOICES-1. For voice v in its cycle:
  - ROM address = current phase[v] (pre-increment);
  - phase[v] <= phase[v] + (BaseInc[v] << Octave), mod 2^PHASE_W;
  - the shift drops overflowed bits;
  - phases free-run regardless of Select.
- Envelope for voice v (in the same cycle; the sample uses the pre-update env):
  - if Select snapshot bit set: env <= min(env+ATTACK_STEP, 2^ENV_W-1);
  - else: env <= max(env-RELEASE_STEP, 0).
- Pipeline per voice:
  - ROM read has 1-cycle latency;
  - then registered product = (amp * {1'b0,env}) >>> ENV_W, signed, truncated toward -inf;
  - then accumulate.
- Accumulator width is 16+clog2(NUM_VOICES)+1; it never overflows.
- DRAIN: waits for the pipeline to empty after the last voice.
- OUTPUT: Out <= saturate(acc >>> MIX_SHIFT) to [-32768, 32767]; OutValid=1 for exactly one cycle; Busy deasserts the same cycle; return to IDLE.
- Latency: OutValid is high in cycle k+NUM_VOICES+3. Out holds its value between pulses.
- A voice with env=0 contributes exactly 0. All env=0 gives Out=0.
- SampleTick while Busy (including the OUTPUT cycle):
  - ignored; Overrun <= 1 (sticky until reset);
  - the computation in progress is unaffected.
- Required tick spacing: >= NUM_VOICES+4 cycles.
- Select/Octave/BaseInc changes during Busy do not affect the current sample. BaseInc is read live per voice cycle; software changes it only while Busy=0.

Test Plan:
1. Reset asserted mid-RUN -> Out=0, OutValid=0, Busy=0, Overrun=0 immediately. No SampleTick afterwards -> OutValid never asserts.
2. NUM_VOICES=12, SampleTick in cycle 100 -> Busy high cycles 101..114; OutValid high only in cycle 115.
3. BaseInc[0]=2^24, Octave=0, then Octave=1 -> voice-0 ROM addresses 0,1,2,... per sample; after change, step 2 per sample (e.g. 3,5,7).
4. ATTACK_STEP=64, Select[0] held 5 samples -> env 0,64,128,192,255 (saturates). Select dropped with RELEASE_STEP=32 -> env reaches 0 after 8 samples; Out then exactly 0.
5. All BaseInc=2^30, MIX_SHIFT=0, all selected: after attack, all voices address 64 (ROM=32767) on the same sample -> Out=32767 (positive saturation, no wrap). With MIX_SHIFT=4 -> Out=(12*32639)>>>4=24479.
6. SampleTick re-pulsed 5 cycles after a tick -> Overrun=1 and stays 1; OutValid still at tick+NUM_VOICES+3; no extra OutValid.
